// File: rtl/avalon_arb_pkg.sv
// Shared types and helpers for the round-robin Avalon-ST arbiter.
package avalon_arb_pkg;

  typedef enum logic {
    IDLE   = 1'b0,
    LOCKED = 1'b1
  } arb_state_t;

  // Width of a source index; never narrower than one bit.
  function automatic int gidx_w(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/avalon_st_if.sv
// Avalon-ST style stream bundle: master drives the beat, slave drives rdy.
interface avalon_st_if #(
  parameter int DATA_WIDTH_IN_BYTES = 16
);
  localparam int EW = (DATA_WIDTH_IN_BYTES <= 1) ? 1 : $clog2(DATA_WIDTH_IN_BYTES);

  logic [8*DATA_WIDTH_IN_BYTES-1:0] data;
  logic                             valid;
  logic                             rdy;
  logic                             sop;
  logic                             eop;
  logic [EW-1:0]                    empty;

  modport master (output data, valid, sop, eop, empty, input rdy);
  modport slave  (input data, valid, sop, eop, empty, output rdy);
endinterface

// File: rtl/rr_pointer_select.sv
// Circular priority search: first set bit of valid starting just after last.
module rr_pointer_select #(
  parameter int N = 4,
  parameter int W = 2
) (
  input  logic [N-1:0] valid,
  input  logic [W-1:0] last,
  output logic [W-1:0] idx,
  output logic         found
);

  // Walk last+1 .. last+N modulo N and keep the first valid index.
  always_comb begin
    int j;
    logic [N-1:0] rot;
    idx   = '0;
    found = 1'b0;
    j     = 0;
    rot   = '0;
    for (int i = 1; i <= N; i++) begin
      j   = (int'(last) + i) % N;
      rot = valid >> j;
      if (!found && rot[0]) begin
        found = 1'b1;
        idx   = W'(j);
      end
    end
  end

endmodule

// File: rtl/avalon_rr_arbiter.sv
// Round-robin packet arbiter merging NUM_SOURCES Avalon-ST streams into one.
// Ownership is held for a whole packet, or until MAX_PKT_BEATS beats without
// eop have been accepted, at which point the owner is forcibly released.
//
// state  | meaning
// IDLE   | no owner; combinational candidate is forwarded
// LOCKED | owner is mid-packet; only the owner is forwarded
module avalon_rr_arbiter
  import avalon_arb_pkg::*;
#(
  parameter int DATA_WIDTH_IN_BYTES = 16,
  parameter int NUM_SOURCES         = 4,
  parameter int MAX_PKT_BEATS       = 256
) (
  input  logic                              clk,
  input  logic                              rst,
  avalon_st_if.slave                        src_msg [NUM_SOURCES],
  avalon_st_if.master                       arb_msg,
  output logic [gidx_w(NUM_SOURCES)-1:0]    grant_idx,
  output logic                              busy,
  output logic                              timeout_indi
);

  localparam int GW = gidx_w(NUM_SOURCES);
  localparam int DW = 8 * DATA_WIDTH_IN_BYTES;
  localparam int EW = (DATA_WIDTH_IN_BYTES <= 1) ? 1 : $clog2(DATA_WIDTH_IN_BYTES);
  localparam int CW = $clog2(MAX_PKT_BEATS + 1);

  arb_state_t       state, state_nx;
  logic [GW-1:0]    owner, owner_nx;
  logic [GW-1:0]    last_grant, last_grant_nx;
  logic [CW-1:0]    beat_cnt, beat_cnt_nx;
  logic             timeout_nx;
  logic [GW-1:0]    cand, sel;
  logic             found, sel_live, accept;

  logic [NUM_SOURCES-1:0] src_valid, src_sop, src_eop, src_rdy;
  logic [DW-1:0]          src_data  [NUM_SOURCES];
  logic [EW-1:0]          src_empty [NUM_SOURCES];

  logic          out_valid, out_sop, out_eop;
  logic [DW-1:0] out_data;
  logic [EW-1:0] out_empty;

  for (genvar g = 0; g < NUM_SOURCES; g++) begin : g_src
    assign src_valid[g]   = src_msg[g].valid;
    assign src_sop[g]     = src_msg[g].sop;
    assign src_eop[g]     = src_msg[g].eop;
    assign src_data[g]    = src_msg[g].data;
    assign src_empty[g]   = src_msg[g].empty;
    assign src_msg[g].rdy = src_rdy[g];
  end

  rr_pointer_select #(
    .N (NUM_SOURCES),
    .W (GW)
  ) u_ptr (
    .valid (src_valid),
    .last  (last_grant),
    .idx   (cand),
    .found (found)
  );

  // Zero-latency mux: forward the selected source, steer rdy back to it only.
  always_comb begin
    sel       = (state == LOCKED) ? owner : cand;
    sel_live  = (state == LOCKED) || found;
    out_valid = 1'b0;
    out_sop   = 1'b0;
    out_eop   = 1'b0;
    out_data  = '0;
    out_empty = '0;
    src_rdy   = '0;
    if (!rst && sel_live) begin
      src_rdy[sel] = arb_msg.rdy;
      if (src_valid[sel]) begin
        out_valid = 1'b1;
        out_sop   = src_sop[sel];
        out_eop   = src_eop[sel];
        out_data  = src_data[sel];
        out_empty = src_empty[sel];
      end
    end
  end

  assign arb_msg.valid = out_valid;
  assign arb_msg.sop   = out_sop;
  assign arb_msg.eop   = out_eop;
  assign arb_msg.data  = out_data;
  assign arb_msg.empty = out_empty;
  assign accept        = out_valid & arb_msg.rdy;
  assign grant_idx     = sel;
  assign busy          = (state == LOCKED);

  // Next-state: lock on a multi-beat packet, release on eop or beat limit.
  always_comb begin
    state_nx      = state;
    owner_nx      = owner;
    last_grant_nx = last_grant;
    beat_cnt_nx   = beat_cnt;
    timeout_nx    = 1'b0;
    case (state)
      IDLE: begin
        if (accept) begin
          last_grant_nx = cand;
          if (!out_eop) begin
            state_nx    = LOCKED;
            owner_nx    = cand;
            beat_cnt_nx = CW'(1);
          end
        end
      end
      LOCKED: begin
        if (accept) begin
          if (out_eop) begin
            state_nx    = IDLE;
            beat_cnt_nx = '0;
          end else if (beat_cnt == CW'(MAX_PKT_BEATS - 1)) begin
            state_nx    = IDLE;
            beat_cnt_nx = '0;
            timeout_nx  = 1'b1;
          end else begin
            beat_cnt_nx = beat_cnt + CW'(1);
          end
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  // State registers; last_grant resets to the top index so source 0 wins first.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= IDLE;
      owner        <= '0;
      last_grant   <= GW'(NUM_SOURCES - 1);
      beat_cnt     <= '0;
      timeout_indi <= 1'b0;
    end else begin
      state        <= state_nx;
      owner        <= owner_nx;
      last_grant   <= last_grant_nx;
      beat_cnt     <= beat_cnt_nx;
      timeout_indi <= timeout_nx;
    end
  end

endmodule

// File: tb/tb_avalon_rr_arbiter.sv
// Scoreboard bench for avalon_rr_arbiter: per-source beat queues drive the
// inputs, expected output beats are queued in arbitration order, and a
// monitor pops and compares every accepted output beat.
module tb_avalon_rr_arbiter;
  import avalon_arb_pkg::*;

  localparam int NS   = 4;
  localparam int DWB  = 16;
  localparam int MAXB = 8;
  localparam int DW   = 8 * DWB;
  localparam int EW   = 4;

  typedef struct {
    logic          gap;
    logic [DW-1:0] data;
    logic          sop;
    logic          eop;
    logic [EW-1:0] empty;
  } beat_t;

  typedef struct {
    int            src;
    logic [DW-1:0] data;
    logic          sop;
    logic          eop;
    logic [EW-1:0] empty;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic sink_rdy = 1'b1;
  always #5 clk = ~clk;

  logic [NS-1:0] s_valid, s_sop, s_eop, s_rdy;
  logic [DW-1:0] s_data  [NS];
  logic [EW-1:0] s_empty [NS];
  logic [1:0]    grant_idx;
  logic          busy, timeout_indi;

  beat_t src_q [NS][$];
  exp_t  exp_q [$];
  logic [NS-1:0] pres_gap;

  int errors = 0;
  int checks = 0;

  avalon_st_if #(.DATA_WIDTH_IN_BYTES(DWB)) src_if [NS] ();
  avalon_st_if #(.DATA_WIDTH_IN_BYTES(DWB)) arb_if ();

  for (genvar g = 0; g < NS; g++) begin : g_drv
    assign src_if[g].valid = s_valid[g];
    assign src_if[g].sop   = s_sop[g];
    assign src_if[g].eop   = s_eop[g];
    assign src_if[g].data  = s_data[g];
    assign src_if[g].empty = s_empty[g];
    assign s_rdy[g]        = src_if[g].rdy;
  end
  assign arb_if.rdy = sink_rdy;

  avalon_rr_arbiter #(
    .DATA_WIDTH_IN_BYTES (DWB),
    .NUM_SOURCES         (NS),
    .MAX_PKT_BEATS       (MAXB)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .src_msg      (src_if),
    .arb_msg      (arb_if),
    .grant_idx    (grant_idx),
    .busy         (busy),
    .timeout_indi (timeout_indi)
  );

  function automatic logic [DW-1:0] dv(input int s, input int b);
    return DW'(32'hA500_0000 | (s << 8) | b);
  endfunction

  task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic add_beat(input int s, input int b, input logic sop, input logic eop);
    beat_t x;
    x.gap = 1'b0; x.data = dv(s, b); x.sop = sop; x.eop = eop; x.empty = EW'(b);
    src_q[s].push_back(x);
  endtask

  task automatic add_gap(input int s);
    beat_t x;
    x.gap = 1'b1; x.data = '0; x.sop = 1'b0; x.eop = 1'b0; x.empty = '0;
    src_q[s].push_back(x);
  endtask

  task automatic exp_beat(input int s, input int b, input logic sop, input logic eop);
    exp_t e;
    e.src = s; e.data = dv(s, b); e.sop = sop; e.eop = eop; e.empty = EW'(b);
    exp_q.push_back(e);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    sink_rdy = 1'b1;
    for (int i = 0; i < NS; i++) src_q[i].delete();
    exp_q.delete();
    repeat (2) @(posedge clk);
    #2;
  endtask

  task automatic rel();
    @(posedge clk);
    #2;
    rst = 1'b0;
  endtask

  task automatic wait_drain(input string name, input int budget);
    int n;
    n = 0;
    while (exp_q.size() > 0 && n < budget) begin
      @(posedge clk);
      n++;
    end
    chk(name, exp_q.size(), 0);
  endtask

  // Source drivers: hold a beat until handshaken; a gap entry idles one cycle.
  initial begin
    logic [NS-1:0] hs;
    beat_t h;
    s_valid = '0; s_sop = '0; s_eop = '0; pres_gap = '0;
    for (int i = 0; i < NS; i++) begin s_data[i] = '0; s_empty[i] = '0; end
    forever begin
      @(negedge clk);
      hs = s_valid & s_rdy;
      @(posedge clk);
      #1;
      for (int i = 0; i < NS; i++) begin
        if (src_q[i].size() > 0 && (pres_gap[i] || hs[i])) void'(src_q[i].pop_front());
        pres_gap[i] = 1'b0;
        if (src_q[i].size() == 0) begin
          s_valid[i] = 1'b0; s_sop[i] = 1'b0; s_eop[i] = 1'b0;
          s_data[i] = '0; s_empty[i] = '0;
        end else begin
          h = src_q[i][0];
          pres_gap[i] = h.gap;
          s_valid[i]  = !h.gap;
          s_sop[i]    = h.sop;
          s_eop[i]    = h.eop;
          s_data[i]   = h.data;
          s_empty[i]  = h.empty;
        end
      end
    end
  end

  // Monitor: every accepted output beat must match the head of the scoreboard.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (!rst && arb_if.valid && arb_if.rdy) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_beat: got src %0d data %0h expected none at %0t",
                   grant_idx, arb_if.data, $time);
        end else begin
          e = exp_q.pop_front();
          chk("beat_src",   grant_idx,    e.src);
          chk("beat_data",  arb_if.data,  e.data);
          chk("beat_sop",   arb_if.sop,   e.sop);
          chk("beat_eop",   arb_if.eop,   e.eop);
          chk("beat_empty", arb_if.empty, e.empty);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset gating with a source already valid, then first grant.
    do_reset();
    add_beat(1, 0, 1'b1, 1'b1);
    exp_beat(1, 0, 1'b1, 1'b1);
    @(negedge clk);
    chk("rst_src_rdy",   s_rdy,        0);
    chk("rst_arb_valid", arb_if.valid, 0);
    chk("rst_busy",      busy,         0);
    chk("rst_timeout",   timeout_indi, 0);
    rel();
    wait_drain("drain_reset", 20);

    // Two 3-beat packets: src0 whole, then src2, no interleave.
    do_reset();
    for (int b = 0; b < 3; b++) begin
      add_beat(0, b, b == 0, b == 2);
      add_beat(2, b, b == 0, b == 2);
    end
    for (int b = 0; b < 3; b++) exp_beat(0, b, b == 0, b == 2);
    for (int b = 0; b < 3; b++) exp_beat(2, b, b == 0, b == 2);
    rel();
    repeat (2) @(negedge clk);
    chk("pkt_grant0", grant_idx, 0);
    chk("pkt_busy0",  busy,      1);
    repeat (2) @(negedge clk);
    chk("pkt_grant2", grant_idx, 2);
    chk("pkt_busy2",  busy,      0);
    wait_drain("drain_pkt", 30);

    // Single-beat packets from all sources rotate 0,1,2,3,0,1 back to back.
    do_reset();
    add_beat(0, 0, 1'b1, 1'b1); add_beat(0, 1, 1'b1, 1'b1);
    add_beat(1, 0, 1'b1, 1'b1); add_beat(1, 1, 1'b1, 1'b1);
    add_beat(2, 0, 1'b1, 1'b1);
    add_beat(3, 0, 1'b1, 1'b1);
    exp_beat(0, 0, 1'b1, 1'b1); exp_beat(1, 0, 1'b1, 1'b1);
    exp_beat(2, 0, 1'b1, 1'b1); exp_beat(3, 0, 1'b1, 1'b1);
    exp_beat(0, 1, 1'b1, 1'b1); exp_beat(1, 1, 1'b1, 1'b1);
    rel();
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      chk("rr_valid", arb_if.valid, 1);
    end
    wait_drain("drain_rr", 20);

    // Owner valid gap: output idles, waiting source stays blocked.
    do_reset();
    add_beat(1, 0, 1'b1, 1'b0);
    add_beat(1, 1, 1'b0, 1'b0);
    add_gap(1); add_gap(1);
    add_beat(1, 2, 1'b0, 1'b1);
    add_beat(3, 0, 1'b1, 1'b1);
    exp_beat(1, 0, 1'b1, 1'b0); exp_beat(1, 1, 1'b0, 1'b0);
    exp_beat(1, 2, 1'b0, 1'b1); exp_beat(3, 0, 1'b1, 1'b1);
    rel();
    repeat (2) @(negedge clk);
    for (int k = 0; k < 2; k++) begin
      @(negedge clk);
      chk("gap_valid", arb_if.valid, 0);
      chk("gap_rdy3",  s_rdy[3],     0);
      chk("gap_busy",  busy,         1);
    end
    wait_drain("drain_gap", 30);

    // Beat limit: src0 forced off after 8 beats, src1 granted, src0 resumes.
    do_reset();
    for (int b = 0; b < 10; b++) add_beat(0, b, b == 0, 1'b0);
    add_beat(1, 0, 1'b1, 1'b1);
    for (int b = 0; b < 8; b++) exp_beat(0, b, b == 0, 1'b0);
    exp_beat(1, 0, 1'b1, 1'b1);
    exp_beat(0, 8, 1'b0, 1'b0);
    exp_beat(0, 9, 1'b0, 1'b0);
    rel();
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      chk("to_quiet", timeout_indi, 0);
    end
    @(negedge clk);
    chk("to_pulse", timeout_indi, 1);
    chk("to_busy",  busy,         0);
    chk("to_grant", grant_idx,    1);
    @(negedge clk);
    chk("to_clear",  timeout_indi, 0);
    chk("to_regrant", grant_idx,   0);
    wait_drain("drain_to", 30);

    // Sink stall mid-packet: owner rdy low, data held, grant unchanged.
    do_reset();
    for (int b = 0; b < 4; b++) add_beat(2, b, b == 0, b == 3);
    add_beat(3, 0, 1'b1, 1'b1);
    for (int b = 0; b < 4; b++) exp_beat(2, b, b == 0, b == 3);
    exp_beat(3, 0, 1'b1, 1'b1);
    rel();
    repeat (2) @(negedge clk);
    @(posedge clk);
    #2 sink_rdy = 1'b0;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk("stall_rdy",   s_rdy,       0);
      chk("stall_data",  arb_if.data, dv(2, 2));
      chk("stall_grant", grant_idx,   2);
      chk("stall_busy",  busy,        1);
    end
    @(posedge clk);
    #2 sink_rdy = 1'b1;
    wait_drain("drain_stall", 30);

    // Reset mid-packet: packet abandoned, src0 wins first afterwards.
    do_reset();
    for (int b = 0; b < 4; b++) add_beat(2, b, b == 0, b == 3);
    exp_beat(2, 0, 1'b1, 1'b0);
    rel();
    @(negedge clk);
    @(posedge clk);
    #2 rst = 1'b1;
    @(negedge clk);
    chk("mrst_busy",  busy,         0);
    chk("mrst_rdy",   s_rdy,        0);
    chk("mrst_valid", arb_if.valid, 0);
    chk("mrst_sb",    exp_q.size(), 0);
    for (int i = 0; i < NS; i++) src_q[i].delete();
    exp_q.delete();
    add_beat(2, 0, 1'b1, 1'b0); add_beat(2, 1, 1'b0, 1'b1);
    add_beat(0, 0, 1'b1, 1'b1);
    exp_beat(0, 0, 1'b1, 1'b1);
    exp_beat(2, 0, 1'b1, 1'b0); exp_beat(2, 1, 1'b0, 1'b1);
    rel();
    @(negedge clk);
    chk("mrst_first", grant_idx, 0);
    wait_drain("drain_mrst", 20);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
